axi_hp_issue_throttle: RTL and testbench

AXI_HP_ISSUE_THROTTLE -- requirements
Module: axi_hp_issue_throttle

---
 rtl/axi_hp_issue_throttle.sv | 197 +++++++++++++++++++
 tb/tb_axi_hp_issue_throttle.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_hp_issue_throttle.sv
// HP port issue throttle: gates AW and AR issue from registered FIFO levels with
// hysteresis. A handshake that is already in flight finishes before the gate closes,
// and ISSUECAP1EN is held high for a while after each throttle releases.
module axi_hp_issue_throttle #(
    parameter int unsigned AW_HIGH  = 12,
    parameter int unsigned AW_LOW   = 8,
    parameter int unsigned W_HIGH   = 96,
    parameter int unsigned W_LOW    = 64,
    parameter int unsigned AR_HIGH  = 6,
    parameter int unsigned AR_LOW   = 4,
    parameter int unsigned R_HIGH   = 96,
    parameter int unsigned R_LOW    = 64,
    parameter int unsigned CAP_HOLD = 16
) (
    input  logic        i_aclk,
    input  logic        i_aresetn,
    // HP port FIFO levels and issue-cap controls
    input  logic [5:0]  i_wacount,
    input  logic [7:0]  i_wcount,
    input  logic [2:0]  i_racount,
    input  logic [7:0]  i_rcount,
    output logic        o_rdissuecap1en,
    output logic        o_wrissuecap1en,
    // AW channel
    input  logic        i_s_awvalid,
    output logic        o_s_awready,
    output logic        o_m_awvalid,
    input  logic        i_m_awready,
    // AR channel
    input  logic        i_s_arvalid,
    output logic        o_s_arready,
    output logic        o_m_arvalid,
    input  logic        i_m_arready,
    // Statistics
    input  logic        i_stat_clr,
    output logic [15:0] o_wr_throttle_cycles,
    output logic [15:0] o_rd_throttle_cycles
);

    // Thresholds must leave a hysteresis band and be reachable by the count.
    if (AW_HIGH <= AW_LOW || AW_HIGH > 63) begin : g_bad_aw
        $error("AW_HIGH must exceed AW_LOW and fit 6 bits");
    end
    if (W_HIGH <= W_LOW || W_HIGH > 255) begin : g_bad_w
        $error("W_HIGH must exceed W_LOW and fit 8 bits");
    end
    if (AR_HIGH <= AR_LOW || AR_HIGH > 7) begin : g_bad_ar
        $error("AR_HIGH must exceed AR_LOW and fit 3 bits");
    end
    if (R_HIGH <= R_LOW || R_HIGH > 255) begin : g_bad_r
        $error("R_HIGH must exceed R_LOW and fit 8 bits");
    end

    localparam int unsigned HOLD_W = (CAP_HOLD == 0) ? 1 : $clog2(CAP_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CAP_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic              HOLD_ANY  = (CAP_HOLD != 0);

    localparam logic [5:0] AW_HI = 6'(AW_HIGH);
    localparam logic [5:0] AW_LO = 6'(AW_LOW);
    localparam logic [7:0] W_HI  = 8'(W_HIGH);
    localparam logic [7:0] W_LO  = 8'(W_LOW);
    localparam logic [2:0] AR_HI = 3'(AR_HIGH);
    localparam logic [2:0] AR_LO = 3'(AR_LOW);
    localparam logic [7:0] R_HI  = 8'(R_HIGH);
    localparam logic [7:0] R_LO  = 8'(R_LOW);

    typedef enum logic [1:0] {StOpen, StPending, StThrottled} state_e;

    logic [5:0]        r_wacount;
    logic [7:0]        r_wcount;
    logic [2:0]        r_racount;
    logic [7:0]        r_rcount;
    state_e            r_wr_state, r_rd_state;
    logic [HOLD_W-1:0] r_wr_hold, r_rd_hold;
    logic              r_wrcap, r_rdcap;
    logic [15:0]       r_wr_stat, r_rd_stat;

    logic w_wr_hi, w_wr_lo, w_rd_hi, w_rd_lo;
    logic w_wr_open, w_rd_open;

    // Register the port FIFO levels once; all compares use these copies.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_wacount <= '0;
            r_wcount  <= '0;
            r_racount <= '0;
            r_rcount  <= '0;
        end else begin
            r_wacount <= i_wacount;
            r_wcount  <= i_wcount;
            r_racount <= i_racount;
            r_rcount  <= i_rcount;
        end
    end

    assign w_wr_hi = (r_wacount >= AW_HI) | (r_wcount >= W_HI);
    assign w_wr_lo = (r_wacount <= AW_LO) & (r_wcount <= W_LO);
    assign w_rd_hi = (r_racount >= AR_HI) | (r_rcount >= R_HI);
    assign w_rd_lo = (r_racount <= AR_LO) & (r_rcount <= R_LO);

    // PENDING keeps the gate open so a presented valid is never withdrawn.
    assign w_wr_open = (r_wr_state != StThrottled);
    assign w_rd_open = (r_rd_state != StThrottled);

    assign o_m_awvalid = i_s_awvalid & w_wr_open & i_aresetn;
    assign o_s_awready = i_m_awready & w_wr_open & i_aresetn;
    assign o_m_arvalid = i_s_arvalid & w_rd_open & i_aresetn;
    assign o_s_arready = i_m_arready & w_rd_open & i_aresetn;

    assign o_wrissuecap1en      = r_wrcap;
    assign o_rdissuecap1en      = r_rdcap;
    assign o_wr_throttle_cycles = r_wr_stat;
    assign o_rd_throttle_cycles = r_rd_stat;

    // Write-channel FSM with registered issue-cap enable and post-release hold.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_wr_state <= StOpen;
            r_wr_hold  <= '0;
            r_wrcap    <= 1'b0;
        end else begin
            unique case (r_wr_state)
                StOpen: begin
                    if (w_wr_hi) begin
                        r_wr_state <= (o_m_awvalid && !i_m_awready) ? StPending : StThrottled;
                        r_wr_hold  <= '0;
                        r_wrcap    <= 1'b1;
                    end else if (r_wr_hold != '0) begin
                        r_wr_hold <= r_wr_hold - HOLD_ONE;
                        r_wrcap   <= (r_wr_hold != HOLD_ONE);
                    end else begin
                        r_wrcap <= 1'b0;
                    end
                end
                StPending: begin
                    if (o_m_awvalid && i_m_awready) r_wr_state <= StThrottled;
                end
                StThrottled: begin
                    if (w_wr_lo) begin
                        r_wr_state <= StOpen;
                        r_wr_hold  <= HOLD_LOAD;
                        r_wrcap    <= HOLD_ANY;
                    end
                end
                default: r_wr_state <= StOpen;
            endcase
        end
    end

    // Read-channel FSM, identical behaviour on the AR/R levels.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_rd_state <= StOpen;
            r_rd_hold  <= '0;
            r_rdcap    <= 1'b0;
        end else begin
            unique case (r_rd_state)
                StOpen: begin
                    if (w_rd_hi) begin
                        r_rd_state <= (o_m_arvalid && !i_m_arready) ? StPending : StThrottled;
                        r_rd_hold  <= '0;
                        r_rdcap    <= 1'b1;
                    end else if (r_rd_hold != '0) begin
                        r_rd_hold <= r_rd_hold - HOLD_ONE;
                        r_rdcap   <= (r_rd_hold != HOLD_ONE);
                    end else begin
                        r_rdcap <= 1'b0;
                    end
                end
                StPending: begin
                    if (o_m_arvalid && i_m_arready) r_rd_state <= StThrottled;
                end
                StThrottled: begin
                    if (w_rd_lo) begin
                        r_rd_state <= StOpen;
                        r_rd_hold  <= HOLD_LOAD;
                        r_rdcap    <= HOLD_ANY;
                    end
                end
                default: r_rd_state <= StOpen;
            endcase
        end
    end

    // Saturating non-OPEN cycle counters; clear wins over increment.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn || i_stat_clr) begin
            r_wr_stat <= '0;
            r_rd_stat <= '0;
        end else begin
            if (r_wr_state != StOpen && r_wr_stat != 16'hFFFF) r_wr_stat <= r_wr_stat + 16'd1;
            if (r_rd_state != StOpen && r_rd_stat != 16'hFFFF) r_rd_stat <= r_rd_stat + 16'd1;
        end
    end

endmodule

// File: tb/tb_axi_hp_issue_throttle.sv
// Bench for axi_hp_issue_throttle: vector table, directed corner sequences and a
// randomized run, all checked every cycle against a behavioural model.
module tb_axi_hp_issue_throttle;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [5:0]  wacount;
    logic [7:0]  wcount;
    logic [2:0]  racount;
    logic [7:0]  rcount;
    logic        rdcap, wrcap;
    logic        s_awvalid, s_awready, m_awvalid, m_awready;
    logic        s_arvalid, s_arready, m_arvalid, m_arready;
    logic        stat_clr;
    logic [15:0] wr_stat, rd_stat;

    always #5 clk = ~clk;

    axi_hp_issue_throttle dut (
        .i_aclk              (clk),
        .i_aresetn           (aresetn),
        .i_wacount           (wacount),
        .i_wcount            (wcount),
        .i_racount           (racount),
        .i_rcount            (rcount),
        .o_rdissuecap1en     (rdcap),
        .o_wrissuecap1en     (wrcap),
        .i_s_awvalid         (s_awvalid),
        .o_s_awready         (s_awready),
        .o_m_awvalid         (m_awvalid),
        .i_m_awready         (m_awready),
        .i_s_arvalid         (s_arvalid),
        .o_s_arready         (s_arready),
        .o_m_arvalid         (m_arvalid),
        .i_m_arready         (m_arready),
        .i_stat_clr          (stat_clr),
        .o_wr_throttle_cycles(wr_stat),
        .o_rd_throttle_cycles(rd_stat)
    );

    localparam int HOLD = 16;
    // Index 0 = write channel (WACOUNT/WCOUNT), 1 = read channel (RACOUNT/RCOUNT).
    int a_hi[2] = '{12, 6};
    int a_lo[2] = '{8, 4};
    int d_hi[2] = '{96, 96};
    int d_lo[2] = '{64, 64};

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: mode 0 = gate open, 1 = waiting for in-flight handshake, 2 = closed.
    int     md_a[2], md_d[2], md_mode[2], md_stat[2];
    longint md_rel[2];
    longint md_cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, md_cyc);
        end
    endtask

    function automatic longint pack(input bit mv, input bit sr, input bit cap, input int st);
        return (longint'(mv) << 18) | (longint'(sr) << 17) | (longint'(cap) << 16) | longint'(st);
    endfunction

    // One clock: compare outputs with the model, cross the edge, advance the model.
    task automatic tick();
        bit sv[2], mr[2], mv[2], op[2], hi, lo;
        int ca[2], cd[2];
        bit rst, clr;
        #1;
        sv[0] = s_awvalid; mr[0] = m_awready; sv[1] = s_arvalid; mr[1] = m_arready;
        ca[0] = int'(wacount); cd[0] = int'(wcount);
        ca[1] = int'(racount); cd[1] = int'(rcount);
        rst = aresetn; clr = stat_clr;
        for (int c = 0; c < 2; c++) begin
            op[c] = rst && (md_mode[c] != 2);
            mv[c] = sv[c] && op[c];
        end
        if (chk_en) begin
            chk("model_wr", pack(m_awvalid, s_awready, wrcap, int'(wr_stat)),
                pack(mv[0], mr[0] && op[0], (md_mode[0] != 0) || (md_cyc - md_rel[0] < HOLD),
                     md_stat[0]));
            chk("model_rd", pack(m_arvalid, s_arready, rdcap, int'(rd_stat)),
                pack(mv[1], mr[1] && op[1], (md_mode[1] != 0) || (md_cyc - md_rel[1] < HOLD),
                     md_stat[1]));
        end
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (!rst) begin
                md_mode[c] = 0; md_a[c] = 0; md_d[c] = 0; md_stat[c] = 0;
                md_rel[c] = -1000000;
            end else begin
                hi = (md_a[c] >= a_hi[c]) || (md_d[c] >= d_hi[c]);
                lo = (md_a[c] <= a_lo[c]) && (md_d[c] <= d_lo[c]);
                if (clr) md_stat[c] = 0;
                else if (md_mode[c] != 0 && md_stat[c] < 65535) md_stat[c]++;
                case (md_mode[c])
                    0: if (hi) md_mode[c] = (mv[c] && !mr[c]) ? 1 : 2;
                    1: if (mv[c] && mr[c]) md_mode[c] = 2;
                    default: if (lo) begin md_mode[c] = 0; md_rel[c] = md_cyc + 1; end
                endcase
                md_a[c] = ca[c];
                md_d[c] = cd[c];
            end
        end
        md_cyc++;
        @(negedge clk);
    endtask

    task automatic set_idle();
        wacount = 0; wcount = 0; racount = 0; rcount = 0;
        s_awvalid = 0; m_awready = 0; s_arvalid = 0; m_arready = 0; stat_clr = 0;
    endtask

    task automatic do_reset();
        set_idle();
        aresetn = 0;
        tick();
        aresetn = 1;
    endtask

    typedef struct {
        int wac, wc, rac, rc;
        bit sav, mar, sarv, marr;
        bit e_maw, e_saw, e_mar, e_sar, e_wcap, e_rcap;
    } vec_t;

    vec_t tbl[9];
    int   ncap;

    initial begin
        // Gate-level stepping of WACOUNT to 12, release at 8, then RACOUNT=6 with WACOUNT=4.
        tbl[0] = '{12, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        tbl[1] = '{12, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        tbl[2] = '{12, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        tbl[3] = '{ 8, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        tbl[4] = '{ 8, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        tbl[5] = '{ 8, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        tbl[6] = '{ 4, 0, 6, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        tbl[7] = '{ 4, 0, 6, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        tbl[8] = '{ 4, 0, 6, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};

        set_idle();
        aresetn = 0;
        @(negedge clk);
        tick();
        tick();
        chk_en = 1'b1;
        #1;
        chk("reset_state", {wrcap, rdcap, wr_stat, rd_stat}, 0);
        aresetn = 1;

        for (int i = 0; i < 9; i++) begin
            wacount = 6'(tbl[i].wac); wcount = 8'(tbl[i].wc);
            racount = 3'(tbl[i].rac); rcount = 8'(tbl[i].rc);
            s_awvalid = tbl[i].sav; m_awready = tbl[i].mar;
            s_arvalid = tbl[i].sarv; m_arready = tbl[i].marr;
            #1;
            chk($sformatf("vec%0d", i),
                {m_awvalid, s_awready, m_arvalid, s_arready, wrcap, rdcap},
                {tbl[i].e_maw, tbl[i].e_saw, tbl[i].e_mar, tbl[i].e_sar,
                 tbl[i].e_wcap, tbl[i].e_rcap});
            tick();
        end

        // Stalled AW valid stays presented until its handshake, then the gate closes.
        do_reset();
        wcount = 100; s_awvalid = 1; m_awready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("pend_valid_held", m_awvalid, 1);
            if (i >= 2) chk("pend_cap", wrcap, 1);
            tick();
        end
        m_awready = 1;
        #1;
        chk("pend_handshake", m_awvalid, 1);
        tick();
        #1;
        chk("pend_closed", m_awvalid, 0);

        // Hysteresis on RCOUNT and the post-release ISSUECAP1EN hold length.
        do_reset();
        rcount = 100; s_arvalid = 1; m_arready = 1;
        repeat (3) tick();
        #1;
        chk("rd_throttled", {m_arvalid, rdcap}, 2'b01);
        rcount = 80;
        repeat (5) tick();
        #1;
        chk("rd_band_stays", {m_arvalid, rdcap}, 2'b01);
        rcount = 64;
        tick();
        tick();
        #1;
        chk("rd_released", m_arvalid, 1);
        ncap = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rdcap) ncap++;
            tick();
        end
        chk("rd_cap_hold_len", ncap, HOLD);

        // Long throttle saturates the statistic; clear coinciding with increment gives 0.
        do_reset();
        racount = 7;
        repeat (70000) tick();
        #1;
        chk("rd_stat_sat", rd_stat, 16'hFFFF);
        stat_clr = 1;
        tick();
        stat_clr = 0;
        #1;
        chk("rd_stat_clr", rd_stat, 0);

        // Reset while both channels are throttled.
        do_reset();
        wacount = 12; racount = 7;
        s_awvalid = 1; m_awready = 1; s_arvalid = 1; m_arready = 1;
        repeat (3) tick();
        #1;
        chk("both_throttled", {wrcap, rdcap, m_awvalid, m_arvalid}, 4'b1100);
        aresetn = 0; wacount = 0; racount = 0;
        #1;
        chk("rst_forced_low", {m_awvalid, m_arvalid, s_awready, s_arready}, 0);
        tick();
        aresetn = 1;
        #1;
        chk("rst_clean", {wrcap, rdcap, wr_stat, rd_stat}, 0);
        chk("rst_gates_open", {m_awvalid, m_arvalid, s_awready, s_arready}, 4'b1111);

        // Randomized traffic around the thresholds, checked against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                wacount = 6'($urandom_range(0, 15));
                wcount  = 8'($urandom_range(50, 110));
            end
            if ($urandom_range(0, 7) == 0) begin
                racount = 3'($urandom_range(0, 7));
                rcount  = 8'($urandom_range(50, 110));
            end
            s_awvalid = 1'($urandom_range(0, 1)); m_awready = 1'($urandom_range(0, 1));
            s_arvalid = 1'($urandom_range(0, 1)); m_arready = 1'($urandom_range(0, 1));
            stat_clr  = ($urandom_range(0, 99) == 0);
            aresetn   = ($urandom_range(0, 799) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
